// File: rtl/cpu_run_monitor.sv
// Run controller/monitor for MIPS_CPU: sequences CPU reset, counts RUN cycles, stops on halt PC or timeout.
// Define CPU_TRACE_EN to build the PC/ALU trace buffer and its read port; otherwise those outputs read 0.
module cpu_run_monitor #(
    parameter int DATA_W     = 32,
    parameter int RST_CYCLES = 4,
    parameter int MAX_CYCLES = 1024,
    parameter int CYC_W      = 16,
    parameter int TRACE_AW   = 6
) (
    input  logic                ClkIn,
    input  logic                Rst,
    input  logic                Start,
    input  logic [DATA_W-1:0]   HaltPC,
    input  logic [DATA_W-1:0]   PCResult,
    input  logic [DATA_W-1:0]   ALUResult,
    output logic                CpuRst,
    output logic                Running,
    output logic                Done,
    output logic                Timeout,
    output logic                Overflow,
    output logic [CYC_W-1:0]    CycleCount,
    output logic [TRACE_AW:0]   TraceCount,
    input  logic [TRACE_AW-1:0] RdAddr,
    output logic [DATA_W-1:0]   RdPC,
    output logic [DATA_W-1:0]   RdALU
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RSTSEQ = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int                RC_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(RST_CYCLES - 1);
    localparam logic [CYC_W-1:0]  CYC_LIMIT = CYC_W'(MAX_CYCLES);
    localparam logic [CYC_W-1:0]  CYC_ONE   = CYC_W'(1);

    state_t           state;
    logic [RC_W-1:0]  rst_cnt;
    logic [CYC_W-1:0] cycle_next;
    logic             start_accept;
    logic             halt_hit;

    assign start_accept = Start && (state == IDLE || state == DONE);
    assign halt_hit     = (PCResult == HaltPC);
    assign cycle_next   = CycleCount + CYC_ONE;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ClkIn or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            rst_cnt    <= '0;
            CpuRst     <= 1'b1;
            Running    <= 1'b0;
            Done       <= 1'b0;
            Timeout    <= 1'b0;
            CycleCount <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_accept) begin
                        state      <= RSTSEQ;
                        rst_cnt    <= RC_LAST;
                        CpuRst     <= 1'b1;
                        Running    <= 1'b0;
                        Done       <= 1'b0;
                        Timeout    <= 1'b0;
                        CycleCount <= '0;
                    end
                end
                RSTSEQ: begin
                    if (rst_cnt == '0) begin
                        state   <= RUN;
                        CpuRst  <= 1'b0;
                        Running <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt - RC_W'(1);
                    end
                end
                RUN: begin
                    CycleCount <= cycle_next;
                    // Halt takes priority over a timeout landing on the same sample.
                    if (halt_hit || cycle_next == CYC_LIMIT) begin
                        state   <= DONE;
                        Running <= 1'b0;
                        Done    <= 1'b1;
                        Timeout <= !halt_hit;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CPU_TRACE_EN
    localparam int DEPTH = 1 << TRACE_AW;

    logic [2*DATA_W-1:0] trace_mem [DEPTH];
    logic [2*DATA_W-1:0] rd_data;
    logic                trace_we;

    // TraceCount never exceeds DEPTH, so its top bit alone means "buffer full".
    assign trace_we = (state == RUN) && !TraceCount[TRACE_AW];

    always_ff @(posedge ClkIn or posedge Rst) begin
        if (Rst) begin
            TraceCount <= '0;
            Overflow   <= 1'b0;
        end else if (start_accept) begin
            TraceCount <= '0;
            Overflow   <= 1'b0;
        end else if (state == RUN) begin
            if (trace_we) TraceCount <= TraceCount + (TRACE_AW+1)'(1);
            else          Overflow   <= 1'b1;
        end
    end

    // NOTE: the trace RAM has no reset so it maps onto plain memory; stale entries are bounded by TraceCount.
    always_ff @(posedge ClkIn) begin
        if (trace_we) trace_mem[TraceCount[TRACE_AW-1:0]] <= {PCResult, ALUResult};
    end

    always_ff @(posedge ClkIn or posedge Rst) begin
        if (Rst) rd_data <= '0;
        else     rd_data <= trace_mem[RdAddr];
    end

    assign RdPC  = rd_data[2*DATA_W-1:DATA_W];
    assign RdALU = rd_data[DATA_W-1:0];
`else
    logic unused_trace_inputs;
    assign unused_trace_inputs = ^{RdAddr, ALUResult};

    assign TraceCount = '0;
    assign Overflow   = 1'b0;
    assign RdPC       = '0;
    assign RdALU      = '0;
`endif

endmodule
